// File: rtl/counter_bank_pkg.sv
// Shared types for the counter bank: per-lane operation codes and the priority decode.
package counter_p;

    typedef enum logic [2:0] {
        CNT_HOLD,
        CNT_GROW,
        CNT_DECAY,
        CNT_INIT,
        CNT_CLEAR
    } cnt_op_e;

    // Clear beats init, both ignore count_en; decay beats growth.
    function automatic cnt_op_e decode_op(
        input logic clear_en,
        input logic init_en,
        input logic count_en,
        input logic decay_en
    );
        if (clear_en)                  return CNT_CLEAR;
        else if (init_en)              return CNT_INIT;
        else if (count_en && decay_en) return CNT_DECAY;
        else if (count_en)             return CNT_GROW;
        else                           return CNT_HOLD;
    endfunction

endpackage

// File: rtl/counter_bank_lane.sv
// One counter lane: seed/clear/grow/decay against a programmable inclusive limit.
// Count and wrap pulse update one cycle after the enables; status flags are combinational from the register.
module counter_bank_lane
    import counter_p::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clk_en_i,
    input  logic                 init_en_i,
    input  logic                 clear_en_i,
    input  logic                 count_en_i,
    input  logic                 decay_en_i,
    input  logic                 saturate_i,
    input  logic                 sticky_clr_i,
    input  logic [BIT_WIDTH-1:0] seed_i,
    input  logic [BIT_WIDTH-1:0] growth_rate_i,
    input  logic [BIT_WIDTH-1:0] decay_rate_i,
    input  logic [BIT_WIDTH-1:0] limit_i,
    output logic [BIT_WIDTH-1:0] count_o,
    output logic                 at_limit_o,
    output logic                 at_zero_o,
    output logic                 wrap_pulse_o,
    output logic                 overflow_sticky_o
);

    localparam int W1 = BIT_WIDTH + 1;

    logic [BIT_WIDTH-1:0] count_d, count_q;
    logic                 wrap_pulse_d, wrap_pulse_q;
    logic                 sticky_d, sticky_q;
    logic                 ovf_evt;
    logic [W1-1:0]        sum_w, limit_w, wrapped_w;
    cnt_op_e              op;

    assign op        = decode_op(clear_en_i, init_en_i, count_en_i, decay_en_i);
    assign limit_w   = {1'b0, limit_i};
    assign sum_w     = {1'b0, count_q} + {1'b0, growth_rate_i};
    assign wrapped_w = sum_w - (limit_w + W1'(1));

    always_comb begin
        count_d      = count_q;
        wrap_pulse_d = 1'b0;
        sticky_d     = sticky_q;
        ovf_evt      = 1'b0;
        if (clk_en_i) begin
            case (op)
                CNT_CLEAR: count_d = '0;
                CNT_INIT:  count_d = (seed_i > limit_i) ? limit_i : seed_i;
                CNT_DECAY: begin
                    if (decay_rate_i != '0)
                        count_d = (count_q > decay_rate_i) ? count_q - decay_rate_i : '0;
                end
                CNT_GROW: begin
                    if (growth_rate_i != '0) begin
                        // Limit lowered below the current count: snap back into range.
                        if (count_q > limit_i) begin
                            ovf_evt = 1'b1;
                            count_d = saturate_i ? limit_i : '0;
                        end else if (sum_w > limit_w) begin
                            ovf_evt = 1'b1;
                            if (saturate_i) begin
                                count_d = limit_i;
                            end else begin
                                wrap_pulse_d = 1'b1;
                                count_d      = (wrapped_w > limit_w) ? '0 : wrapped_w[BIT_WIDTH-1:0];
                            end
                        end else begin
                            count_d = sum_w[BIT_WIDTH-1:0];
                        end
                    end
                end
                default: count_d = count_q;
            endcase
            if (ovf_evt)
                sticky_d = 1'b1;
            else if (sticky_clr_i)
                sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q      <= '0;
            wrap_pulse_q <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrap_pulse_q <= wrap_pulse_d;
            sticky_q     <= sticky_d;
        end
    end

    assign count_o           = count_q;
    assign at_limit_o        = (count_q == limit_i);
    assign at_zero_o         = (count_q == '0);
    assign wrap_pulse_o      = wrap_pulse_q;
    assign overflow_sticky_o = sticky_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of CHANNELS independent grow/decay counters with limit, saturate/wrap and overflow flags.
// One-cycle update latency per lane; no backpressure, lanes share only clock, reset and clk_en_i.
module counter_bank
    import counter_p::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int CHANNELS  = 4
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_n_i,
    input  logic                          clk_en_i,
    input  logic [CHANNELS-1:0]           init_en_i,
    input  logic [CHANNELS-1:0]           clear_en_i,
    input  logic [CHANNELS-1:0]           count_en_i,
    input  logic [CHANNELS-1:0]           decay_en_i,
    input  logic [CHANNELS-1:0]           saturate_i,
    input  logic [CHANNELS-1:0]           sticky_clr_i,
    input  logic [CHANNELS*BIT_WIDTH-1:0] seed_i,
    input  logic [CHANNELS*BIT_WIDTH-1:0] growth_rate_i,
    input  logic [CHANNELS*BIT_WIDTH-1:0] decay_rate_i,
    input  logic [CHANNELS*BIT_WIDTH-1:0] limit_i,
    output logic [CHANNELS*BIT_WIDTH-1:0] count_o,
    output logic [CHANNELS-1:0]           at_limit_o,
    output logic [CHANNELS-1:0]           at_zero_o,
    output logic [CHANNELS-1:0]           wrap_pulse_o,
    output logic [CHANNELS-1:0]           overflow_sticky_o
);

    for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
        counter_bank_lane #(
            .BIT_WIDTH(BIT_WIDTH)
        ) u_lane (
            .clk_i            (sys_clk_i),
            .rst_n_i          (sys_rst_n_i),
            .clk_en_i         (clk_en_i),
            .init_en_i        (init_en_i[n]),
            .clear_en_i       (clear_en_i[n]),
            .count_en_i       (count_en_i[n]),
            .decay_en_i       (decay_en_i[n]),
            .saturate_i       (saturate_i[n]),
            .sticky_clr_i     (sticky_clr_i[n]),
            .seed_i           (seed_i[n*BIT_WIDTH +: BIT_WIDTH]),
            .growth_rate_i    (growth_rate_i[n*BIT_WIDTH +: BIT_WIDTH]),
            .decay_rate_i     (decay_rate_i[n*BIT_WIDTH +: BIT_WIDTH]),
            .limit_i          (limit_i[n*BIT_WIDTH +: BIT_WIDTH]),
            .count_o          (count_o[n*BIT_WIDTH +: BIT_WIDTH]),
            .at_limit_o       (at_limit_o[n]),
            .at_zero_o        (at_zero_o[n]),
            .wrap_pulse_o     (wrap_pulse_o[n]),
            .overflow_sticky_o(overflow_sticky_o[n])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Directed test of counter_bank with a per-lane behavioural model checked every falling edge.
module tb_counter_bank;
    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clk_en = 1'b1;
    logic [N-1:0]   init_en = '0, clear_en = '0, count_en = '0, decay_en = '0;
    logic [N-1:0]   saturate = '0, sticky_clr = '0;
    logic [N*W-1:0] seed = '0, growth = '0, decay = '0, limit = '0;
    logic [N*W-1:0] count_o;
    logic [N-1:0]   at_limit_o, at_zero_o, wrap_pulse_o, sticky_o;

    int n_checks = 0;
    int n_fail   = 0;

    int mcnt[N];
    bit mpulse[N];
    bit msticky[N];

    always #5 clk = ~clk;

    counter_bank #(.BIT_WIDTH(W), .CHANNELS(N)) dut (
        .sys_clk_i(clk), .sys_rst_n_i(rst_n), .clk_en_i(clk_en),
        .init_en_i(init_en), .clear_en_i(clear_en), .count_en_i(count_en),
        .decay_en_i(decay_en), .saturate_i(saturate), .sticky_clr_i(sticky_clr),
        .seed_i(seed), .growth_rate_i(growth), .decay_rate_i(decay), .limit_i(limit),
        .count_o(count_o), .at_limit_o(at_limit_o), .at_zero_o(at_zero_o),
        .wrap_pulse_o(wrap_pulse_o), .overflow_sticky_o(sticky_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Next-state of one lane straight from the behaviour rules: {overflow, wrap, next_count}.
    function automatic logic [33:0] step_lane(input int l);
        int  cnt, sd, gr, dr, lm, nxt, s;
        bit  ev, wp;
        cnt = mcnt[l];
        sd  = int'(seed[l*W +: W]);
        gr  = int'(growth[l*W +: W]);
        dr  = int'(decay[l*W +: W]);
        lm  = int'(limit[l*W +: W]);
        nxt = cnt; ev = 0; wp = 0;
        if (clear_en[l])                     nxt = 0;
        else if (init_en[l])                 nxt = (sd < lm) ? sd : lm;
        else if (count_en[l] && decay_en[l]) nxt = (cnt - dr < 0) ? 0 : cnt - dr;
        else if (count_en[l] && gr != 0) begin
            s = cnt + gr;
            if (cnt > lm) begin
                ev = 1; nxt = saturate[l] ? lm : 0;
            end else if (s > lm) begin
                ev = 1;
                if (saturate[l]) nxt = lm;
                else begin
                    wp  = 1;
                    nxt = s - (lm + 1);
                    if (nxt > lm) nxt = 0;
                end
            end else nxt = s;
        end
        return {ev, wp, nxt[31:0]};
    endfunction

    function automatic int nxt_of(input int l);
        logic [33:0] r;
        r = step_lane(l);
        return int'(r[31:0]);
    endfunction

    function automatic bit wp_of(input int l);
        logic [33:0] r;
        r = step_lane(l);
        return r[32];
    endfunction

    function automatic bit ev_of(input int l);
        logic [33:0] r;
        r = step_lane(l);
        return r[33];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mcnt[i] <= 0; mpulse[i] <= 0; msticky[i] <= 0;
            end
        end else if (clk_en) begin
            for (int i = 0; i < N; i++) begin
                mcnt[i]    <= nxt_of(i);
                mpulse[i]  <= wp_of(i);
                msticky[i] <= ev_of(i) ? 1'b1 : (sticky_clr[i] ? 1'b0 : msticky[i]);
            end
        end else begin
            for (int i = 0; i < N; i++) mpulse[i] <= 0;
        end
    end

    function automatic logic [N*W-1:0] exp_count();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = mcnt[i][W-1:0];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_flag(input int kind);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++)
            case (kind)
                0: v[i] = (mcnt[i] == int'(limit[i*W +: W]));
                1: v[i] = (mcnt[i] == 0);
                2: v[i] = mpulse[i];
                default: v[i] = msticky[i];
            endcase
        return v;
    endfunction

    always @(negedge clk) begin
        check("model_count",    64'(count_o),      64'(exp_count()));
        check("model_at_limit", 64'(at_limit_o),   64'(exp_flag(0)));
        check("model_at_zero",  64'(at_zero_o),    64'(exp_flag(1)));
        check("model_wrap",     64'(wrap_pulse_o), 64'(exp_flag(2)));
        check("model_sticky",   64'(sticky_o),     64'(exp_flag(3)));
    end

    // Inputs are changed 1 time unit after a falling edge, after the compare process.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        init_en = '0; clear_en = '0; count_en = '0; decay_en = '0; sticky_clr = '0;
    endtask

    task automatic load(input int l, input logic [W-1:0] sd, input logic [W-1:0] lm);
        seed[l*W +: W] = sd; limit[l*W +: W] = lm;
        idle(); init_en[l] = 1'b1; tick(); idle();
    endtask

    initial begin
        limit[0 +: W] = 16'd5;
        tick();
        check("rst_count",    64'(count_o),    64'd0);
        check("rst_at_zero",  64'(at_zero_o),  64'hF);
        check("rst_at_limit", 64'(at_limit_o), 64'hE);
        check("rst_flags",    64'({wrap_pulse_o, sticky_o}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Asynchronous reset between edges.
        load(0, 16'd37, 16'd1000);
        check("pre_rst_37", 64'(count_o[0 +: W]), 64'd37);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 64'(count_o),   64'd0);
        check("async_rst_zero",  64'(at_zero_o), 64'hF);
        #1 rst_n = 1'b1;
        tick();

        // Saturate clamp.
        load(0, 16'd95, 16'd100);
        growth[0 +: W] = 16'd10; saturate[0] = 1'b1; count_en[0] = 1'b1;
        tick(); idle();
        check("sat_count",  64'(count_o[0 +: W]), 64'd100);
        check("sat_flags",  64'({at_limit_o[0], sticky_o[0], wrap_pulse_o[0]}), 64'b110);

        // Wrap: 96 + 10 against limit 99 -> 6; sticky cleared in the load cycle.
        seed[0 +: W] = 16'd96; limit[0 +: W] = 16'd99;
        init_en[0] = 1'b1; sticky_clr[0] = 1'b1; tick(); idle();
        check("sticky_cleared", 64'(sticky_o[0]), 64'd0);
        saturate[0] = 1'b0; count_en[0] = 1'b1;
        tick(); idle();
        check("wrap_count", 64'(count_o[0 +: W]), 64'd6);
        check("wrap_flags", 64'({wrap_pulse_o[0], sticky_o[0]}), 64'b11);
        tick();
        check("wrap_pulse_gone", 64'(wrap_pulse_o[0]), 64'd0);
        sticky_clr[0] = 1'b1; tick(); idle();
        check("sticky_clr", 64'(sticky_o[0]), 64'd0);
        load(0, 16'd96, 16'd99);
        count_en[0] = 1'b1; sticky_clr[0] = 1'b1; tick(); idle();
        check("set_beats_clr", 64'({count_o[0 +: W], sticky_o[0]}), {47'd0, 16'd6, 1'b1});

        // Decay floor, then init overriding a decay.
        sticky_clr[0] = 1'b1; tick(); idle();
        load(0, 16'd3, 16'd150);
        decay[0 +: W] = 16'd5; count_en[0] = 1'b1; decay_en[0] = 1'b1;
        tick(); idle();
        check("decay_floor", 64'({count_o[0 +: W], wrap_pulse_o[0], sticky_o[0]}), 64'd0);
        seed[0 +: W] = 16'd200; init_en[0] = 1'b1; count_en[0] = 1'b1; decay_en[0] = 1'b1;
        tick(); idle();
        check("init_clamp", 64'({count_o[0 +: W], at_limit_o[0]}), {47'd0, 16'd150, 1'b1});

        // Priority and clock-enable gating.
        clear_en[0] = 1'b1; init_en[0] = 1'b1; count_en[0] = 1'b1;
        tick(); idle();
        check("clear_wins", 64'(count_o[0 +: W]), 64'd0);
        load(0, 16'd10, 16'd150);
        growth[0 +: W] = 16'd4; count_en[0] = 1'b1; clk_en = 1'b0;
        tick(); tick();
        check("clk_en_hold", 64'({count_o[0 +: W], wrap_pulse_o[0]}), {47'd0, 16'd10, 1'b0});
        clk_en = 1'b1; tick(); idle();
        check("clk_en_resume", 64'(count_o[0 +: W]), 64'd14);
        growth[0 +: W] = 16'd0; count_en[0] = 1'b1; tick(); idle();
        check("zero_growth_hold", 64'({count_o[0 +: W], sticky_o[0]}), {47'd0, 16'd14, 1'b0});

        // Lane independence with a full-range wrap on lane 2.
        for (int i = 0; i < N; i++) limit[i*W +: W] = 16'hFFFF;
        seed = {16'h3333, 16'hFFFE, 16'h2222, 16'h1111};
        init_en = '1; tick(); idle();
        growth[2*W +: W] = 16'd3; count_en[2] = 1'b1;
        tick(); idle();
        check("lane_indep_count", 64'(count_o), 64'h3333_0001_2222_1111);
        check("lane_indep_wrap",  64'(wrap_pulse_o), 64'b0100);

        // Limit lowered below the count: saturate snaps to limit, wrap snaps to 0.
        limit[1*W +: W] = 16'h0100; limit[3*W +: W] = 16'h0100;
        growth[1*W +: W] = 16'd1; growth[3*W +: W] = 16'd1;
        saturate[1] = 1'b1; saturate[3] = 1'b0; count_en[1] = 1'b1; count_en[3] = 1'b1;
        tick(); idle();
        check("lowered_limit", 64'(count_o), 64'h0000_0001_0100_1111);
        check("lowered_sticky", 64'(sticky_o & 4'b1010), 64'b1010);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
